// File: rtl/viterbi_pkg.sv
// Shared constants and trellis helpers for the 4-state K=3 (7,5) hard-decision Viterbi datapath.
package viterbi_pkg;

  localparam int NUM_STATES = 4;
  localparam int DEF_PM_W   = 3;
  localparam logic [DEF_PM_W-1:0] PM_MAX = {DEF_PM_W{1'b1}};
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  // Encoder register is {u, s[1], s[0]}; each output is the parity of its tapped bits.
  function automatic logic [1:0] branch_out(input logic [1:0] s, input logic u);
    logic [2:0] r;
    r = {u, s};
    return {^(r & G0), ^(r & G1)};
  endfunction

  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

endpackage

// File: rtl/pm_compare.sv
// Borrow-based two-way metric compare: picks b only when it is strictly smaller than a.
module pm_compare #(
  parameter int PM_W = 3
) (
  input  logic [PM_W-1:0] a_i,
  input  logic [PM_W-1:0] b_i,
  output logic            sel_o,
  output logic [PM_W-1:0] min_o
);

  logic [PM_W:0] diff_s;

  assign diff_s = {1'b0, a_i} - {1'b0, b_i};
  // No borrow and a nonzero difference means b < a; equality keeps a.
  assign sel_o  = !diff_s[PM_W] && (diff_s[PM_W-1:0] != {PM_W{1'b0}});
  assign min_o  = sel_o ? b_i : a_i;

endmodule

// File: rtl/viterbi_acs_pm_unit.sv
// Add-compare-select and normalised path-metric registers for the 4-state (7,5) Viterbi decoder.
module viterbi_acs_pm_unit
  import viterbi_pkg::*;
#(
  parameter int PM_W  = DEF_PM_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       rx_sym,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       dec,
  output logic [1:0]       best_state,
  output logic [CNT_W-1:0] sym_cnt
);

  localparam logic [PM_W-1:0] PM_SAT = {PM_W{1'b1}};
  localparam logic [NUM_STATES-1:0][PM_W-1:0] PM_INIT = {PM_SAT, PM_SAT, PM_SAT, {PM_W{1'b0}}};

  logic [NUM_STATES-1:0][PM_W-1:0] pm_q, pm_d;
  logic [NUM_STATES-1:0]           dec_q, dec_d;
  logic [1:0]                      best_q, best_d;
  logic                            out_valid_q, out_valid_d;
  logic [CNT_W-1:0]                sym_cnt_q, sym_cnt_d;

  logic [PM_W-1:0]       cand0_s   [NUM_STATES];
  logic [PM_W-1:0]       cand1_s   [NUM_STATES];
  logic [PM_W-1:0]       sel_pm_s  [NUM_STATES];
  logic [PM_W-1:0]       pm_norm_s [NUM_STATES];
  logic [NUM_STATES-1:0] sel_s;
  logic [PM_W-1:0]       min01_s, min23_s, min_s;
  logic                  sel01_s, sel23_s, sel_all_s;
  logic [1:0]            best_s;
  logic                  accept_s;

  genvar g;
  generate
    for (g = 0; g < NUM_STATES; g++) begin : g_acs
      // Next state {u,a} is reached from {a,0} and {a,1} with input u.
      localparam logic [1:0] NS = 2'(g);
      localparam logic [1:0] P0 = {NS[0], 1'b0};
      localparam logic [1:0] P1 = {NS[0], 1'b1};

      logic [1:0]    bm0_s, bm1_s;
      logic [PM_W:0] sum0_s, sum1_s;

      assign bm0_s  = hamming2(rx_sym, branch_out(P0, NS[1]));
      assign bm1_s  = hamming2(rx_sym, branch_out(P1, NS[1]));
      assign sum0_s = {1'b0, pm_q[P0]} + {{(PM_W-1){1'b0}}, bm0_s};
      assign sum1_s = {1'b0, pm_q[P1]} + {{(PM_W-1){1'b0}}, bm1_s};
      assign cand0_s[g] = sum0_s[PM_W] ? PM_SAT : sum0_s[PM_W-1:0];
      assign cand1_s[g] = sum1_s[PM_W] ? PM_SAT : sum1_s[PM_W-1:0];

      pm_compare #(.PM_W(PM_W)) u_sel (
        .a_i   (cand0_s[g]),
        .b_i   (cand1_s[g]),
        .sel_o (sel_s[g]),
        .min_o (sel_pm_s[g])
      );

      assign pm_norm_s[g] = sel_pm_s[g] - min_s;
    end
  endgenerate

  pm_compare #(.PM_W(PM_W)) u_min01 (
    .a_i   (sel_pm_s[0]),
    .b_i   (sel_pm_s[1]),
    .sel_o (sel01_s),
    .min_o (min01_s)
  );

  pm_compare #(.PM_W(PM_W)) u_min23 (
    .a_i   (sel_pm_s[2]),
    .b_i   (sel_pm_s[3]),
    .sel_o (sel23_s),
    .min_o (min23_s)
  );

  pm_compare #(.PM_W(PM_W)) u_min_all (
    .a_i   (min01_s),
    .b_i   (min23_s),
    .sel_o (sel_all_s),
    .min_o (min_s)
  );

  // Every stage of the min tree keeps the lower index on ties, so this is the first zero state.
  assign best_s   = {sel_all_s, (sel_all_s ? sel23_s : sel01_s)};
  assign in_ready = !start && (!out_valid_q || out_ready);
  assign accept_s = in_valid && in_ready;

  // Next-state: start wins, then an accepted beat, then output drain.
  always_comb begin
    pm_d        = pm_q;
    dec_d       = dec_q;
    best_d      = best_q;
    out_valid_d = out_valid_q;
    sym_cnt_d   = sym_cnt_q;
    if (start) begin
      pm_d        = PM_INIT;
      sym_cnt_d   = {CNT_W{1'b0}};
      out_valid_d = 1'b0;
    end else if (accept_s) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        pm_d[i] = pm_norm_s[i];
      end
      dec_d       = sel_s;
      best_d      = best_s;
      out_valid_d = 1'b1;
      if (sym_cnt_q != {CNT_W{1'b1}}) begin
        sym_cnt_d = sym_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        sym_cnt_d = sym_cnt_q;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_q        <= PM_INIT;
      dec_q       <= {NUM_STATES{1'b0}};
      best_q      <= 2'd0;
      out_valid_q <= 1'b0;
      sym_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      pm_q        <= pm_d;
      dec_q       <= dec_d;
      best_q      <= best_d;
      out_valid_q <= out_valid_d;
      sym_cnt_q   <= sym_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign dec        = dec_q;
  assign best_state = best_q;
  assign sym_cnt    = sym_cnt_q;

endmodule
